// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared limb width, FSM state encoding and index-width helper for adder_seq_ctrl
package adder_seq_pkg;
    localparam int LIMB_W = 5;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
    function automatic int idx_w(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/Adder_5_bit.sv
// Adder_5_bit: 5-bit ripple datapath shared by the limb sequencer
module Adder_5_bit (
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       Cin,
    output logic [4:0] S,
    output logic       Cout
);
    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {5'b0, Cin};
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: adds two W-bit operands one 5-bit limb per cycle through a single Adder_5_bit
// SUBTRACT_EN adds op_sub: a-b via inverted b and forced carry-in.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int NUM_LIMBS = 4,
    localparam int W = LIMB_W * NUM_LIMBS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SUBTRACT_EN
    input  logic         op_sub,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int IW = idx_w(NUM_LIMBS);

    state_t state, nxt;
    logic [W-1:0] a_r, b_r;
    logic [IW-1:0] idx;
    logic carry, last, acc, sub, lc;
    logic [LIMB_W-1:0] la, lb, ls;

`ifdef SUBTRACT_EN
    assign sub = op_sub;
`else
    assign sub = 1'b0;
`endif

    assign acc  = state == IDLE && start;
    assign last = idx == IW'(NUM_LIMBS - 1);

    always_comb begin
        la = '0;
        lb = '0;
        for (int k = 0; k < NUM_LIMBS; k++)
            if (idx == IW'(k)) begin
                la = a_r[k*LIMB_W +: LIMB_W];
                lb = b_r[k*LIMB_W +: LIMB_W];
            end
    end

    Adder_5_bit u_add (.A(la), .B(lb), .Cin(carry), .S(ls), .Cout(lc));

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;

    always_comb
        nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;

    always_comb begin
        ready = state == IDLE;
        busy  = state == RUN || state == DONE;
        done  = state == DONE;
    end

    // b_r holds the effective operand, so the overflow test is the same for add and subtract
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (acc) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == RUN) begin
            for (int k = 0; k < NUM_LIMBS; k++)
                if (idx == IW'(k)) sum[k*LIMB_W +: LIMB_W] <= ls;
            carry <= lc;
            idx   <= idx + 1'b1;
            if (last) begin
                cout <= lc;
                ovf  <= (a_r[W-1] == b_r[W-1]) && (ls[LIMB_W-1] != a_r[W-1]);
            end
        end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: random and directed scoreboard bench over 2-, 4- and 8-limb instances
module tb_adder_seq_ctrl;
`ifdef SUBTRACT_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    typedef struct packed {
        logic [39:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, op_sub = 1'b0;
    logic [39:0] a = '0, b = '0;
    logic r2, bz2, d2, co2, ov2, r4, bz4, d4, co4, ov4, r8, bz8, d8, co8, ov8;
    logic [9:0]  s2;
    logic [19:0] s4;
    logic [39:0] s8;

    exp_t q[3][$];
    logic [39:0] hold[3];
    int nvec = 0, nerr = 0, cyc = 0, lastd = -100, hs_cyc = 0;
    bit hs = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_seq_ctrl #(.NUM_LIMBS(2)) u2 (.clk(clk), .rst(rst), .start(start), .a(a[9:0]), .b(b[9:0]), .cin(cin),
`ifdef SUBTRACT_EN
        .op_sub(op_sub),
`endif
        .ready(r2), .busy(bz2), .done(d2), .sum(s2), .cout(co2), .ovf(ov2));
    adder_seq_ctrl #(.NUM_LIMBS(4)) u4 (.clk(clk), .rst(rst), .start(start), .a(a[19:0]), .b(b[19:0]), .cin(cin),
`ifdef SUBTRACT_EN
        .op_sub(op_sub),
`endif
        .ready(r4), .busy(bz4), .done(d4), .sum(s4), .cout(co4), .ovf(ov4));
    adder_seq_ctrl #(.NUM_LIMBS(8)) u8 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SUBTRACT_EN
        .op_sub(op_sub),
`endif
        .ready(r8), .busy(bz8), .done(d8), .sum(s8), .cout(co8), .ovf(ov8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unsigned result and carry from integer arithmetic, overflow from the signed range
    function automatic exp_t model(input int w, input logic [39:0] x, input logic [39:0] y, input logic c, input logic sub);
        longint m, h, ua, ub, sa, sb, r, sr;
        exp_t e;
        m  = (longint'(1) << w) - 1;
        h  = longint'(1) << (w - 1);
        ua = longint'(x) & m;
        ub = longint'(y) & m;
        sa = ua >= h ? ua - (m + 1) : ua;
        sb = ub >= h ? ub - (m + 1) : ub;
        r  = sub ? ua - ub : ua + ub + longint'(c);
        sr = sub ? sa - sb : sa + sb + longint'(c);
        e.s  = 40'(r & m);
        e.co = sub ? (ua >= ub) : (((r >> w) & 1) != 0);
        e.ov = sr >= h || sr < -h;
        return e;
    endfunction

    task automatic mon(input int id, input int w, input string nm, input logic rdy, input logic dn,
                       input logic [39:0] s, input logic co, input logic ov);
        exp_t e;
        if (rst) begin
            q[id].delete();
            hold[id] = '0;
            return;
        end
        if (dn) begin
            chk({nm, "_done_expected"}, 64'(q[id].size()), 1);
            if (q[id].size() > 0) begin
                e = q[id].pop_front();
                chk({nm, "_sum"}, s, e.s);
                chk({nm, "_cout"}, co, e.co);
                chk({nm, "_ovf"}, ov, e.ov);
            end
            hold[id] = s;
            if (id == 1) begin
                if (hs && lastd > hs_cyc) chk("n4_done_gap", 64'(cyc - lastd), 6);
                lastd = cyc;
            end
        end else if (rdy) chk({nm, "_sum_hold"}, s, hold[id]);
        if (rdy && start) q[id].push_back(model(w, a, b, cin, SUB_ON && op_sub));
    endtask

    always @(negedge clk) begin
        mon(0, 10, "n2", r2, d2, 40'(s2), co2, ov2);
        mon(1, 20, "n4", r4, d4, 40'(s4), co4, ov4);
        mon(2, 40, "n8", r8, d8, s8, co8, ov8);
    end

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && r2 && r4 && r8) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", 64'(ok), 1);
    endtask

    task automatic go(input logic [39:0] x, input logic [39:0] y, input logic c, input logic s);
        @(posedge clk);
        #1;
        a = x; b = y; cin = c; op_sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = {8'($urandom), $urandom};
        b = {8'($urandom), $urandom};
        cin = 1'($urandom);
        op_sub = 1'($urandom);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", r4, 1);
        chk("rst_busy", bz4, 0);
        chk("rst_done", d4, 0);
        chk("rst_sum", s4, 0);
        chk("rst_cout", co4, 0);
        chk("rst_ovf", ov4, 0);
        rst = 1'b0;

        // abort mid-run, then rerun the same add
        @(posedge clk);
        #1;
        a = 40'h1; b = 40'h1; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ready", r4, 1);
        chk("abort_busy", bz4, 0);
        chk("abort_sum", s4, 0);
        chk("abort_cout", co4, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        go(40'h1, 40'h1, 1'b0, 1'b0);
        chk("rerun_sum", s4, 20'h00002);
        chk("rerun_cout", co4, 0);
        chk("rerun_ovf", ov4, 0);

        go(40'hFFFFF, 40'h1, 1'b0, 1'b0);
        chk("ripple_sum", s4, 20'h0);
        chk("ripple_cout", co4, 1);
        chk("ripple_ovf", ov4, 0);
        go(40'hFFFFF, 40'h0, 1'b1, 1'b0);
        chk("ripple_cin_sum", s4, 20'h0);
        chk("ripple_cin_cout", co4, 1);
        go(40'h7FFFF, 40'h1, 1'b0, 1'b0);
        chk("povf_sum", s4, 20'h80000);
        chk("povf_cout", co4, 0);
        chk("povf_ovf", ov4, 1);
        go(40'h80000, 40'h80000, 1'b0, 1'b0);
        chk("novf_sum", s4, 20'h0);
        chk("novf_cout", co4, 1);
        chk("novf_ovf", ov4, 1);

        if (SUB_ON) begin
            go(40'h5, 40'h7, 1'b0, 1'b1);
            chk("sub_neg_sum", s4, 20'hFFFFE);
            chk("sub_neg_cout", co4, 0);
            go(40'h7, 40'h5, 1'b1, 1'b1);
            chk("sub_pos_sum", s4, 20'h00002);
            chk("sub_pos_cout", co4, 1);
        end

        // start held high with operands changing every cycle
        hs_cyc = cyc;
        hs = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            a = {8'($urandom), $urandom};
            b = {8'($urandom), $urandom};
            cin = 1'($urandom);
            op_sub = 1'($urandom);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        hs = 1'b0;

        for (int i = 0; i < 1000; i++)
            go({8'($urandom), $urandom}, {8'($urandom), $urandom}, 1'($urandom), 1'($urandom));

        repeat (3) @(posedge clk);
        #1;
        chk("final_queues", 64'(q[0].size() + q[1].size() + q[2].size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
